// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a valid/ready
// handshake. Splits the instruction into fields, generates control signals,
// resolves BZ/BC from the execute flags, and interlocks on load-use and
// flag-use hazards.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (opcode 11xxx flags
// out_illegal and sets a sticky trap that blocks input until flush/reset).
// Without the macro, 11xxx decodes as a NOP and out_illegal is tied low.
`timescale 1ns/1ps
module decode_stage #(
  parameter int INST_W   = 16,
  parameter int RA_W     = 3,
  parameter int LOAD_LAT = 1,
  parameter int FLAG_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_W-1:0]          inst,
  input  logic [3:0]                 flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_regw,
  output logic                       out_memw,
  output logic                       out_flagsw,
  output logic                       out_alusrc,
  output logic                       out_pcs,
  output logic                       out_port_write,
  output logic [3:0]                 out_alu_ctrl,
  output logic [RA_W-1:0]            out_rd,
  output logic [RA_W-1:0]            out_rs,
  output logic [INST_W-6-2*RA_W-1:0] out_imm,
  output logic                       out_illegal
);

  localparam int IMM_W = INST_W - 6 - 2*RA_W;

  localparam logic [4:0] OP_JMP = 5'b10000;
  localparam logic [4:0] OP_BZ  = 5'b10001;
  localparam logic [4:0] OP_JAL = 5'b10010;
  localparam logic [4:0] OP_BC  = 5'b10011;
  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_ST  = 5'b10101;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;

  // Instruction fields
  logic [4:0]       op;
  logic [RA_W-1:0]  rd;
  logic [RA_W-1:0]  rs;
  logic [IMM_W-1:0] imm;
  logic             funct;

  assign op    = inst[INST_W-1 -: 5];
  assign rd    = inst[INST_W-6 -: RA_W];
  assign rs    = inst[INST_W-6-RA_W -: RA_W];
  assign imm   = inst[IMM_W:1];
  assign funct = inst[0];

  // Only Z and C take part in branch resolution; N and V are carried for
  // future condition codes.
  logic unused_flags;
  assign unused_flags = ^{flags[3], flags[0]};

  // Decoded controls for the incoming instruction
  logic       regw_d, memw_d, flagsw_d, alusrc_d, pcs_d, port_write_d;
  logic [3:0] alu_ctrl_d;
  logic       illegal_d;

  logic in_fire;
  logic hazard_ld, hazard_fl, hazard;
  logic trap;
  logic out_valid_q;

  // Combinational decode of the opcode map, including branch resolution
  always_comb begin
    regw_d       = 1'b0;
    memw_d       = 1'b0;
    flagsw_d     = 1'b0;
    alusrc_d     = funct;
    pcs_d        = 1'b0;
    port_write_d = 1'b0;
    alu_ctrl_d   = 4'b1111;
    illegal_d    = 1'b0;
    if (!op[4]) begin
      regw_d     = 1'b1;
      flagsw_d   = 1'b1;
      alu_ctrl_d = op[3:0];
    end else begin
      case (op)
        OP_JMP:  pcs_d = 1'b1;
        OP_BZ:   pcs_d = flags[2];
        OP_JAL: begin
          pcs_d  = 1'b1;
          regw_d = 1'b1;
        end
        OP_BC:   pcs_d = flags[1];
        OP_LD:   regw_d = 1'b1;
        OP_ST:   memw_d = 1'b1;
        OP_IN:   regw_d = 1'b1;
        OP_OUT:  port_write_d = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        default: illegal_d = 1'b1;
`else
        default: illegal_d = 1'b0;
`endif
      endcase
    end
  end

  assign hazard   = hazard_ld | hazard_fl;
  assign in_ready = !reset && !flush && !trap && (!out_valid_q || out_ready) && !hazard;
  assign in_fire  = in_valid && in_ready;

  // Load-use interlock: count down bubbles after LD and block readers of its rd
  if (LOAD_LAT > 0) begin : g_ld
    localparam int LDW = $clog2(LOAD_LAT + 1);
    logic [LDW-1:0]  ld_cnt_q;
    logic [RA_W-1:0] ld_rd_q;

    // Counter reloads on LD acceptance, otherwise drains to zero every cycle
    always_ff @(posedge clk) begin
      if (reset || flush)
        ld_cnt_q <= '0;
      else if (in_fire && op == OP_LD)
        ld_cnt_q <= LDW'(LOAD_LAT);
      else if (ld_cnt_q != '0)
        ld_cnt_q <= ld_cnt_q - LDW'(1);
    end

    // Destination register of the most recent LD
    always_ff @(posedge clk) begin
      if (in_fire && op == OP_LD)
        ld_rd_q <= rd;
    end

    // JMP, JAL and IN never read a register, so they pass through
    assign hazard_ld = (ld_cnt_q != '0) &&
                       !(op == OP_JMP || op == OP_JAL || op == OP_IN) &&
                       (rd == ld_rd_q || rs == ld_rd_q);
  end else begin : g_no_ld
    assign hazard_ld = 1'b0;
  end

  // Flag-use interlock: conditional branches wait for fresh flags
  if (FLAG_LAT > 0) begin : g_fl
    localparam int FLW = $clog2(FLAG_LAT + 1);
    logic [FLW-1:0] fl_cnt_q;

    // Counter reloads on a flag-writing acceptance, otherwise drains to zero
    always_ff @(posedge clk) begin
      if (reset || flush)
        fl_cnt_q <= '0;
      else if (in_fire && flagsw_d)
        fl_cnt_q <= FLW'(FLAG_LAT);
      else if (fl_cnt_q != '0)
        fl_cnt_q <= fl_cnt_q - FLW'(1);
    end

    assign hazard_fl = (fl_cnt_q != '0) && (op == OP_BZ || op == OP_BC);
  end else begin : g_no_fl
    assign hazard_fl = 1'b0;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_q;
  logic out_illegal_q;

  // Sticky trap: set by an accepted illegal opcode, cleared only by flush/reset
  always_ff @(posedge clk) begin
    if (reset || flush)
      trap_q <= 1'b0;
    else if (in_fire && illegal_d)
      trap_q <= 1'b1;
  end

  // Registered illegal indication travelling with the other outputs
  always_ff @(posedge clk) begin
    if (reset)
      out_illegal_q <= 1'b0;
    else if (in_fire)
      out_illegal_q <= illegal_d;
  end

  assign trap        = trap_q;
  assign out_illegal = out_illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
  assign trap           = 1'b0;
  assign out_illegal    = 1'b0;
`endif

  // ---- decode -> execute register boundary ----
  logic                 regw_q, memw_q, flagsw_q, alusrc_q, pcs_q, port_write_q;
  logic [3:0]           alu_ctrl_q;
  logic [RA_W-1:0]      rd_q, rs_q;
  logic [IMM_W-1:0]     imm_q;

  // Output register: capture on accept, drop valid when consumed or flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      regw_q       <= 1'b0;
      memw_q       <= 1'b0;
      flagsw_q     <= 1'b0;
      alusrc_q     <= 1'b0;
      pcs_q        <= 1'b0;
      port_write_q <= 1'b0;
      alu_ctrl_q   <= 4'b1111;
      rd_q         <= '0;
      rs_q         <= '0;
      imm_q        <= '0;
    end else begin
      if (flush)
        out_valid_q <= 1'b0;
      else if (in_fire)
        out_valid_q <= 1'b1;
      else if (out_ready)
        out_valid_q <= 1'b0;

      if (in_fire) begin
        regw_q       <= regw_d;
        memw_q       <= memw_d;
        flagsw_q     <= flagsw_d;
        alusrc_q     <= alusrc_d;
        pcs_q        <= pcs_d;
        port_write_q <= port_write_d;
        alu_ctrl_q   <= alu_ctrl_d;
        rd_q         <= rd;
        rs_q         <= rs;
        imm_q        <= imm;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_regw       = regw_q;
  assign out_memw       = memw_q;
  assign out_flagsw     = flagsw_q;
  assign out_alusrc     = alusrc_q;
  assign out_pcs        = pcs_q;
  assign out_port_write = port_write_q;
  assign out_alu_ctrl   = alu_ctrl_q;
  assign out_rd         = rd_q;
  assign out_rs         = rs_q;
  assign out_imm        = imm_q;

endmodule
